// File: rtl/pwm16_fader.sv
// pwm16_fader: slew-rate limited duty fader; define PWM16_FADER_GAMMA_EN for squared (gamma) output
module pwm16_fader #(
    parameter int unsigned STEP_DIV  = 256,
    parameter logic [15:0] STEP_SIZE = 16'h0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] target,
    output logic [15:0] level,
    output logic        busy,
    output logic        done
);
    typedef enum logic {IDLE, FADING} state_t;
    state_t state, state_nxt;
    logic [15:0] cnt, cur, cur_nxt, diff, step;
    logic tick, up, done_nxt;
    assign tick = cnt == 16'(STEP_DIV - 1);
    assign up = target > cur;
    // distance is taken before stepping so the step clamps exactly onto the target
    assign diff = up ? target - cur : cur - target;
    assign step = diff < STEP_SIZE ? diff : STEP_SIZE;
    assign cur_nxt = !tick ? cur : up ? cur + step : cur - step;
    assign busy = state == FADING;
    always_comb begin
        state_nxt = cur_nxt != target ? FADING : IDLE;
        done_nxt = tick && cur != target && cur_nxt == target;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= 16'd0;
            cur <= 16'd0;
            done <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt <= tick ? 16'd0 : cnt + 16'd1;
            cur <= cur_nxt;
            done <= done_nxt;
        end
    end
`ifdef PWM16_FADER_GAMMA_EN
    logic [31:0] sq;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sq <= 32'd0;
            level <= 16'd0;
        end else begin
            sq <= 32'(cur) * 32'(cur);
            level <= sq[31:16];
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) level <= 16'd0;
        else level <= cur;
    end
`endif
endmodule

// File: tb/tb_pwm16_fader.sv
// tb_pwm16_fader: three faders with different step sizes checked against a per-cycle behavioural model
module tb_pwm16_fader;
`ifdef PWM16_FADER_GAMMA_EN
    localparam bit G = 1'b1;
`else
    localparam bit G = 1'b0;
`endif
    localparam int DIV = 4;
    localparam int SZ[3] = '{1, 3, 16'h1000};
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [15:0] tgt[3];
    logic [15:0] level[3];
    logic busy[3], done[3];
    int errs = 0, checks = 0;
    always #5 clk = ~clk;
    pwm16_fader #(.STEP_DIV(DIV), .STEP_SIZE(16'd1)) u0 (
        .clk(clk), .reset(reset), .target(tgt[0]), .level(level[0]), .busy(busy[0]), .done(done[0]));
    pwm16_fader #(.STEP_DIV(DIV), .STEP_SIZE(16'd3)) u1 (
        .clk(clk), .reset(reset), .target(tgt[1]), .level(level[1]), .busy(busy[1]), .done(done[1]));
    pwm16_fader #(.STEP_DIV(DIV), .STEP_SIZE(16'h1000)) u2 (
        .clk(clk), .reset(reset), .target(tgt[2]), .level(level[2]), .busy(busy[2]), .done(done[2]));
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [15:0] explv(input logic [15:0] v);
        return G ? 16'((32'(v) * 32'(v)) >> 16) : v;
    endfunction
    // model: cur after each edge, plus the two previous values for output latency
    int mc[3], mc1[3], mc2[3];
    bit mb[3], md[3];
    int n, c, t, s;
    bit tk;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n = 0;
            for (int i = 0; i < 3; i++) begin
                mc[i] = 0; mc1[i] = 0; mc2[i] = 0; mb[i] = 0; md[i] = 0;
            end
        end else begin
            tk = (n % DIV) == DIV - 1;
            n++;
            for (int i = 0; i < 3; i++) begin
                c = mc[i];
                t = int'(tgt[i]);
                mc2[i] = mc1[i];
                mc1[i] = mc[i];
                md[i] = 0;
                if (tk && c != t) begin
                    s = t > c ? t - c : c - t;
                    if (s > SZ[i]) s = SZ[i];
                    c = t > c ? c + s : c - s;
                    md[i] = c == t;
                    mc[i] = c;
                end
                mb[i] = mc[i] != t;
            end
        end
    end
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("level%0d", i), level[i], G ? explv(16'(mc2[i])) : 16'(mc1[i]));
            chk($sformatf("busy%0d", i), busy[i], mb[i]);
            chk($sformatf("done%0d", i), done[i], md[i]);
        end
    end
    initial begin
        int dn;
        int w;
        logic [15:0] q[$];
        logic [15:0] exp_dn[5];
        exp_dn = '{16'd10, 16'd7, 16'd4, 16'd1, 16'd0};
        tgt = '{16'h1234, 16'h1234, 16'h1234};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", level[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_done", done[0], 0);
        @(negedge clk);
        tgt = '{16'd10, 16'd10, 16'hFFFF};
        reset = 1'b1;
        dn = 0;
        for (int k = 1; k <= 44; k++) begin
            @(posedge clk);
            #1;
            dn += int'(done[0]);
            if (k == 1) chk("busy_rise", busy[0], 1);
            if (k == 20) chk("ramp_mid", level[0], explv(16'd4));
            if (k == 34) chk("full_half", level[2], G ? 16'h4000 : 16'h8000);
            if (k == 40) begin
                chk("done_at_40", done[0], 1);
                chk("busy_fall", busy[0], 0);
            end
            if (k == 42) chk("ramp_end", level[0], explv(16'd10));
        end
        chk("done_once_up", dn, 1);
        @(negedge clk);
        tgt[1] = 16'd0;
        q.push_back(level[1]);
        dn = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            dn += int'(done[1]);
            if (level[1] != q[$]) q.push_back(level[1]);
        end
        chk("done_once_down", dn, 1);
        chk("down_final", level[1], 0);
`ifndef PWM16_FADER_GAMMA_EN
        chk("down_len", q.size(), 5);
        for (int i = 0; i < 5 && i < q.size(); i++) chk($sformatf("down_seq%0d", i), q[i], exp_dn[i]);
`endif
        chk("full_up", level[2], explv(16'hFFFF));
        chk("full_up_busy", busy[2], 0);
        @(negedge clk);
        tgt[0] = 16'd100;
        tgt[2] = 16'd0;
        repeat (160) @(posedge clk);
        @(negedge clk);
        tgt[0] = 16'd20;
        for (w = 0; w < 400; w++) begin
            @(posedge clk);
            #1;
            if (!busy[0]) break;
        end
        chk("rev_in_time", w < 400, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("rev_final", level[0], explv(16'd20));
        chk("full_down", level[2], 0);
        @(negedge clk);
        tgt[0] = 16'd200;
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async_clr_level", level[0], 0);
        chk("async_clr_busy", busy[0], 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_level", level[0], 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("restart", level[0], explv(16'd2));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
